data_memory_bank: RTL and testbench

Parametrised successor to the single-port data memory used by the processor datapath's load/store stage. Byte-addressed synchronous RAM with byte/half/word(/dword) access sizes, lane-shifted stores and sign/zero-extended loads. Adds a configurable read pipeline, misalignment/range error detection, and a post-reset clear sweep that zeroes every word before accepting requests. Sits between the execute stage and the register-file write-back mux.

---
 rtl/data_memory_bank.sv | 125 ++++++++++++
 tb/tb_data_memory_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bank.sv
// Byte-addressed single-port data RAM for the load/store stage: sized, lane-shifted stores,
// extended loads, a READ_LATENCY-deep read pipeline, request error checks and a post-reset zeroing sweep.
module data_memory_bank #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  ena,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  dvalid,
  output logic                  misalign,
  output logic                  busy
);
  localparam int NB     = DATA_WIDTH / 8;
  localparam int L      = $clog2(NB);
  localparam int SW     = $clog2(DATA_WIDTH);
  localparam int IW     = $clog2(DEPTH);
  localparam int WIW    = ADDR_WIDTH - L;
  localparam int STAGES = READ_LATENCY;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]            state;
  logic [IW-1:0]         clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [WIW-1:0]        widx;
  logic [IW-1:0]         ridx;
  logic [L-1:0]          off, amask;
  logic [3:0]            nbytes;
  logic [6:0]            bits;
  logic                  acc, err_any, st_ok, st_err, ld_ok, ld_err;
  logic [7:0]            lane_mask;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata, rd_word, sh, msk, ld_val;
  logic [SW-1:0]         sidx;

  assign widx    = addra[ADDR_WIDTH-1:L];
  assign ridx    = widx[IW-1:0];
  assign off     = addra[L-1:0];
  assign nbytes  = 4'd1 << size;
  assign bits    = {nbytes, 3'b000};
  assign amask   = L'(nbytes - 4'd1);
  assign err_any = ((off & amask) != '0) || ((size == 2'd3) && (DATA_WIDTH == 32))
                 || (widx >= WIW'(DEPTH));
  assign acc     = rsta_n && ena && (state == ST_IDLE);
  assign st_ok   = acc &&  we && !err_any;
  assign st_err  = acc &&  we &&  err_any;
  assign ld_ok   = acc && !we && !err_any;
  assign ld_err  = acc && !we &&  err_any;

  // Store data arrives right-aligned; move it and its byte enables up to the addressed lane.
  assign lane_mask = 8'((9'h1 << nbytes) - 9'h1);
  assign be        = NB'(lane_mask) << off;
  assign wdata     = dina << {off, 3'b000};

  assign rd_word = mem[ridx];
  assign sh      = rd_word >> {off, 3'b000};
  assign sidx    = SW'(bits - 7'd1);

  always_comb begin
    msk = '1;
    if (bits < 7'(DATA_WIDTH))
      msk = (DATA_WIDTH'(1) << bits) - DATA_WIDTH'(1);
    ld_val = sh & msk;
    if (sign_ext && sh[sidx])
      ld_val = ld_val | ~msk;
  end

  always_ff @(posedge clka) begin
    if (rsta_n && state == ST_CLEAR)
      mem[clr_cnt] <= '0;
    else if (st_ok)
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[ridx][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IW'(DEPTH - 1)) state <= ST_IDLE;
    end
  end

  // Read pipeline: data stages only load on a valid entry, so the last stage doubles as the held douta.
  logic [STAGES:1]                 vld_pipe, err_pipe;
  logic [STAGES:1][DATA_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= ld_ok;
      err_pipe[1] <= ld_err;
      if (ld_ok) dat_pipe[1] <= ld_val;
      for (int k = 2; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        err_pipe[k] <= err_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
      // Store errors always report one cycle after acceptance, whatever the read depth.
      if (st_err) err_pipe[STAGES] <= 1'b1;
    end
  end

  assign douta    = dat_pipe[STAGES];
  assign dvalid   = vld_pipe[STAGES];
  assign misalign = err_pipe[STAGES];
  assign busy     = (state == ST_CLEAR);
endmodule

// File: tb/tb_data_memory_bank.sv
// Two instances (32-bit RL=2, 64-bit RL=1) driven by directed vectors, hand sequences and random traffic,
// checked every cycle against a byte-array / event-queue reference model.
module tb_data_memory_bank;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena0 = 1'b0, ena1 = 1'b0, we = 1'b0, sx = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0;
  logic [63:0] din = '0;
  logic [31:0] d0;
  logic [63:0] d1;
  logic        v0, m0, b0, v1, m1, b1;

  always #5 clk = ~clk;

  data_memory_bank #(.DATA_WIDTH(32), .DEPTH(D), .ADDR_WIDTH(32), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u0 (
    .clka(clk), .rsta_n(rst_n), .ena(ena0), .we(we), .size(size), .sign_ext(sx), .addra(addr),
    .dina(din[31:0]), .douta(d0), .dvalid(v0), .misalign(m0), .busy(b0));
  data_memory_bank #(.DATA_WIDTH(64), .DEPTH(D), .ADDR_WIDTH(32), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
    .clka(clk), .rsta_n(rst_n), .ena(ena1), .we(we), .size(size), .sign_ext(sx), .addra(addr),
    .dina(din), .douta(d1), .dvalid(v1), .misalign(m1), .busy(b1));

  int n_cmp = 0, n_fail = 0;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference model: memory as bytes, results as events due on a given edge number.
  typedef struct { int inst; int due; bit err; logic [63:0] data; } ev_t;
  ev_t         evq[$];
  logic [7:0]  mem_m [2][128];
  int          busy_rem [2];
  logic [63:0] exp_d [2];
  bit          exp_v [2], exp_m [2];
  int          cyc = 0;

  function automatic int nb_of(int i); return (i == 0) ? 4 : 8; endfunction
  function automatic int lat_of(int i); return (i == 0) ? 2 : 1; endfunction

  task automatic model_req(input int i);
    int B, n, lat;
    bit bad;
    logic [63:0] v;
    B = nb_of(i); lat = lat_of(i); n = 1 << size;
    bad = (addr % n != 0) || (size == 2'd3 && B == 4) || (addr / B >= D);
    if (bad) evq.push_back('{i, cyc + (we ? 0 : lat - 1), 1'b1, 64'd0});
    else if (we) begin
      for (int k = 0; k < n; k++) mem_m[i][addr + k] = din[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[i][addr + k];
      if (sx && v[n*8-1])
        for (int b = n * 8; b < B * 8; b++) v[b] = 1'b1;
      evq.push_back('{i, cyc + lat - 1, 1'b0, v});
    end
  endtask

  task automatic model_edge();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int k = evq.size() - 1; k >= 0; k--) if (evq[k].inst == i) evq.delete(k);
        exp_d[i] = '0;
        busy_rem[i] = D;
        for (int j = 0; j < 128; j++) mem_m[i][j] = 8'h00;
      end else if (busy_rem[i] > 0) busy_rem[i]--;
      else if (i == 0 ? ena0 : ena1) model_req(i);
      exp_v[i] = 1'b0; exp_m[i] = 1'b0;
      for (int k = 0; k < evq.size(); k++)
        if (evq[k].inst == i && evq[k].due == cyc) begin
          if (evq[k].err) exp_m[i] = 1'b1;
          else begin exp_v[i] = 1'b1; exp_d[i] = evq[k].data; end
        end
      for (int k = evq.size() - 1; k >= 0; k--)
        if (evq[k].inst == i && evq[k].due <= cyc) evq.delete(k);
    end
  endtask

  task automatic check_all();
    cmp("stream0_ctl", {61'd0, b0, v0, m0}, {61'd0, busy_rem[0] > 0, exp_v[0], exp_m[0]});
    cmp("stream0_data", {32'd0, d0}, {32'd0, exp_d[0][31:0]});
    cmp("stream1_ctl", {61'd0, b1, v1, m1}, {61'd0, busy_rem[1] > 0, exp_v[1], exp_m[1]});
    cmp("stream1_data", d1, exp_d[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((b0 || b1) && g < 50) begin cycle(); g++; end
    cmp("idle_after_sweep", {62'd0, b0, b1}, 64'd0);
  endtask

  typedef struct {
    int inst; bit we; logic [1:0] size; bit sx; logic [31:0] addr; logic [63:0] din;
    bit err; logic [63:0] exp;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int cnt0, cnt1, g;
    logic gv, gm;
    logic [63:0] gd;
    bit got_v [6];
    logic [31:0] got_d [6];
    logic [31:0] b2b_exp [4];

    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h3C, 64'd0, 1'b0, 64'd0});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h0, 64'd54, 1'b0, 64'd0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h0, 64'd0, 1'b0, 64'd54});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h8, 64'h11223344, 1'b0, 64'd0});
    tbl.push_back('{0, 1'b1, 2'd0, 1'b0, 32'h9, 64'hAB, 1'b0, 64'd0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h8, 64'd0, 1'b0, 64'h1122AB44});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b1, 32'h9, 64'd0, 1'b0, 64'hFFFFFFAB});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b0, 32'h9, 64'd0, 1'b0, 64'h000000AB});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b1, 32'hA, 64'd0, 1'b0, 64'h00001122});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h4, 64'hDEADBEEF, 1'b0, 64'd0});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b0, 32'h3, 64'd0, 1'b1, 64'd0});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h6, 64'h55555555, 1'b1, 64'd0});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h40, 64'h66666666, 1'b1, 64'd0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h4, 64'd0, 1'b0, 64'hDEADBEEF});
    tbl.push_back('{0, 1'b0, 2'd3, 1'b0, 32'h0, 64'd0, 1'b1, 64'd0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h80000000, 64'd0, 1'b1, 64'd0});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b1, 32'h6, 64'd0, 1'b0, 64'hFFFFDEAD});
    tbl.push_back('{1, 1'b1, 2'd3, 1'b0, 32'h10, 64'h0123456789ABCDEF, 1'b0, 64'd0});
    tbl.push_back('{1, 1'b0, 2'd2, 1'b0, 32'h14, 64'd0, 1'b0, 64'h0000000001234567});
    tbl.push_back('{1, 1'b0, 2'd2, 1'b1, 32'h10, 64'd0, 1'b0, 64'hFFFFFFFF89ABCDEF});
    tbl.push_back('{1, 1'b0, 2'd1, 1'b0, 32'h16, 64'd0, 1'b0, 64'h0000000000000123});
    tbl.push_back('{1, 1'b0, 2'd0, 1'b1, 32'h13, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFF89});
    tbl.push_back('{1, 1'b0, 2'd3, 1'b0, 32'h10, 64'd0, 1'b0, 64'h0123456789ABCDEF});
    tbl.push_back('{1, 1'b0, 2'd3, 1'b0, 32'h14, 64'd0, 1'b1, 64'd0});
    tbl.push_back('{1, 1'b1, 2'd2, 1'b0, 32'h80, 64'h77777777, 1'b1, 64'd0});

    // Reset, then count the sweep length on both instances.
    @(negedge clk);
    rst_n = 1'b0;
    cycle();
    cmp("rst_outputs0", {31'd0, v0, m0, d0}, 64'd0);
    cmp("rst_outputs1", {62'd0, v1, m1}, 64'd0);
    cmp("rst_douta1", d1, 64'd0);
    rst_n = 1'b1;
    cnt0 = 0; cnt1 = 0; g = 0;
    while ((b0 || b1) && g < 40) begin
      if (b0) cnt0++;
      if (b1) cnt1++;
      cycle(); g++;
    end
    cmp("busy_len0", 64'(cnt0), 64'(D));
    cmp("busy_len1", 64'(cnt1), 64'(D));

    foreach (tbl[j]) begin
      we = tbl[j].we; size = tbl[j].size; sx = tbl[j].sx; addr = tbl[j].addr; din = tbl[j].din;
      if (tbl[j].inst == 0) ena0 = 1'b1; else ena1 = 1'b1;
      cycle();
      ena0 = 1'b0; ena1 = 1'b0;
      if (!tbl[j].we)
        for (int k = 1; k < lat_of(tbl[j].inst); k++) cycle();
      gv = (tbl[j].inst == 0) ? v0 : v1;
      gm = (tbl[j].inst == 0) ? m0 : m1;
      gd = (tbl[j].inst == 0) ? {32'd0, d0} : d1;
      cmp($sformatf("vec%0d_status", j), {62'd0, gv, gm},
          {62'd0, !tbl[j].we && !tbl[j].err, tbl[j].err});
      if (!tbl[j].we && !tbl[j].err) cmp($sformatf("vec%0d_data", j), gd, tbl[j].exp);
    end

    // Back-to-back loads on the 2-deep pipeline: four consecutive results.
    b2b_exp[0] = 32'd54; b2b_exp[1] = 32'hDEADBEEF; b2b_exp[2] = 32'h1122AB44; b2b_exp[3] = 32'd0;
    we = 1'b0; size = 2'd2; sx = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ena0 = (k < 4); addr = 32'(4 * k);
      cycle();
      got_v[k] = v0; got_d[k] = d0;
    end
    ena0 = 1'b0;
    for (int k = 0; k < 6; k++) cmp($sformatf("b2b_valid%0d", k), {63'd0, got_v[k]}, {63'd0, k >= 1 && k <= 4});
    for (int k = 1; k <= 4; k++) cmp($sformatf("b2b_data%0d", k), {32'd0, got_d[k]}, {32'd0, b2b_exp[k-1]});

    // Load immediately after a store to the same word.
    ena0 = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h20; din = 64'hCAFEF00D;
    cycle();
    we = 1'b0;
    cycle();
    ena0 = 1'b0;
    cycle();
    cmp("raw_data", {31'd0, v0, d0}, {31'd0, 1'b1, 32'hCAFEF00D});

    // Reset while a load is in flight: it must vanish and douta must clear.
    ena0 = 1'b1; we = 1'b0; addr = 32'h4;
    cycle();
    rst_n = 1'b0; addr = 32'h8;
    cycle();
    cmp("flush_at_reset", {31'd0, v0, d0}, 64'd0);
    rst_n = 1'b1; ena0 = 1'b0;
    cycle();
    cmp("flush_after_reset", {62'd0, v0, b0}, {62'd0, 1'b0, 1'b1});
    wait_idle();

    // Random traffic with occasional resets, checked cycle by cycle by the model.
    for (int t = 0; t < 600; t++) begin
      ena0 = ($urandom % 4) != 0;
      ena1 = ($urandom % 4) != 0;
      we   = $urandom % 2;
      size = 2'($urandom % 4);
      sx   = $urandom % 2;
      addr = $urandom_range(0, 135);
      if ($urandom % 4 != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      din  = {$urandom, $urandom};
      rst_n = ($urandom % 200) != 0;
      cycle();
    end
    ena0 = 1'b0; ena1 = 1'b0; rst_n = 1'b1;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
